// File: rtl/zorro_dma_master.sv
// ============================================================================
// zorro_dma_master
// Zorro II bus-master engine: arbitrates for the bus and runs 16-bit cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module zorro_dma_master #(
  parameter int TIMEOUT  = 64,
  parameter int MAX_HOLD = 16
) (
  input  logic        C7M,
  input  logic        RESETn,
  input  logic        req,
  input  logic        req_wr,
  input  logic [22:0] req_addr,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  input  logic        req_last,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic        BRn,
  input  logic        BGn,
  input  logic        BGACKn_in,
  output logic        BGACKn,
  output logic        OWNn,
  input  logic        ASn_in,
  input  logic        DTACKn,
  input  logic        BERRn,
  output logic        bus_oe,
  output logic [22:0] ADDR,
  output logic        ASn,
  output logic        UDSn,
  output logic        LDSn,
  output logic        READ,
  output logic [15:0] D_out,
  output logic        D_oe,
  input  logic [15:0] D_in
);

  localparam int c_CMAX = (TIMEOUT > MAX_HOLD) ? TIMEOUT : MAX_HOLD;
  localparam int c_CW   = $clog2(c_CMAX + 1);
  localparam logic [c_CW-1:0] c_TIMEOUT  = c_CW'(TIMEOUT);
  localparam logic [c_CW-1:0] c_HOLD_END = c_CW'(MAX_HOLD - 1);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0, ST_ARB = 4'd1, ST_S0 = 4'd2, ST_S1 = 4'd3, ST_S2 = 4'd4,
    ST_WAIT = 4'd5, ST_TERM = 4'd6, ST_HOLD = 4'd7, ST_REL = 4'd8
  } state_t;

  state_t r_state, w_state;
  logic [c_CW-1:0] r_cnt, w_cnt;
  logic r_wr, w_wr, r_last, w_last;
  logic [1:0] r_be, w_be;
  logic r_bg_n, r_bgack_in_n, r_as_in_n, r_dtack_n, r_berr_n;
  logic r_br_n, w_br_n, r_bgack_n, w_bgack_n, r_as_n, w_as_n;
  logic r_uds_n, w_uds_n, r_lds_n, w_lds_n, r_read, w_read;
  logic r_bus_oe, w_bus_oe, r_doe, w_doe, r_ack, w_ack, r_err, w_err;
  logic [22:0] r_addr, w_addr;
  logic [15:0] r_dout, w_dout, r_rdata, w_rdata;
  logic w_req_ok, w_start, w_rel, w_term;

  // req is ignored during the ack cycle, when it still carries the old request
  assign w_req_ok = req && !r_ack;

  always_comb begin
    w_state = r_state;   w_cnt = r_cnt;       w_wr = r_wr;
    w_be = r_be;         w_last = r_last;     w_br_n = r_br_n;
    w_bgack_n = r_bgack_n; w_as_n = r_as_n;   w_uds_n = r_uds_n;
    w_lds_n = r_lds_n;   w_read = r_read;     w_bus_oe = r_bus_oe;
    w_addr = r_addr;     w_dout = r_dout;     w_doe = r_doe;
    w_rdata = r_rdata;   w_ack = 1'b0;        w_err = 1'b0;
    w_start = 1'b0;      w_rel = 1'b0;        w_term = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_ok) begin
          if (req_be == 2'b00) begin
            w_ack = 1'b1;
            w_err = 1'b1;
          end else begin
            w_br_n  = 1'b0;
            w_state = ST_ARB;
          end
        end
      end
      ST_ARB: begin
        if (!r_bg_n && r_as_in_n && r_bgack_in_n && r_dtack_n) begin
          w_br_n    = 1'b1;
          w_bgack_n = 1'b0;
          w_start   = 1'b1;
        end
      end
      ST_S0: begin
        w_as_n = 1'b0;
        if (!r_wr) begin
          w_uds_n = !r_be[1];
          w_lds_n = !r_be[0];
        end
        w_state = ST_S1;
      end
      ST_S1: begin
        if (r_wr) begin
          w_uds_n = !r_be[1];
          w_lds_n = !r_be[0];
        end
        w_cnt   = c_CW'(1);
        w_state = ST_S2;
      end
      ST_S2: begin
        w_cnt   = r_cnt + 1'b1;
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt = r_cnt + 1'b1;
        if (!r_berr_n) begin
          w_term = 1'b1;
          w_err  = 1'b1;
        end else if (!r_dtack_n) begin
          w_term = 1'b1;
          if (!r_wr) w_rdata = D_in;
        end else if (r_cnt == c_TIMEOUT) begin
          w_term = 1'b1;
          w_err  = 1'b1;
        end
      end
      ST_TERM: begin
        w_doe   = 1'b0;
        w_cnt   = '0;
        w_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_dtack_n && r_berr_n) begin
          if (r_last) begin
            w_rel = 1'b1;
          end else if (w_req_ok && req_be != 2'b00) begin
            w_start = 1'b1;
          end else if (w_req_ok) begin
            w_ack = 1'b1;
            w_err = 1'b1;
            w_cnt = '0;
          end else if (r_cnt == c_HOLD_END) begin
            w_rel = 1'b1;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      ST_REL:  w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase

    if (w_start) begin
      w_state  = ST_S0;
      w_bus_oe = 1'b1;
      w_addr   = req_addr;
      w_read   = !req_wr;
      w_doe    = req_wr;
      w_dout   = req_wdata;
      w_wr     = req_wr;
      w_be     = req_be;
      w_last   = req_last;
    end
    if (w_term) begin
      w_as_n  = 1'b1;
      w_uds_n = 1'b1;
      w_lds_n = 1'b1;
      w_ack   = 1'b1;
      w_state = ST_TERM;
    end
    if (w_rel) begin
      w_bus_oe  = 1'b0;
      w_bgack_n = 1'b1;
      w_state   = ST_REL;
    end
  end

  always_ff @(posedge C7M) begin
    if (!RESETn) begin
      r_state <= ST_IDLE;  r_cnt <= '0;        r_wr <= 1'b0;
      r_be <= 2'b00;       r_last <= 1'b0;
      r_bg_n <= 1'b1;      r_bgack_in_n <= 1'b1; r_as_in_n <= 1'b1;
      r_dtack_n <= 1'b1;   r_berr_n <= 1'b1;
      r_br_n <= 1'b1;      r_bgack_n <= 1'b1;  r_as_n <= 1'b1;
      r_uds_n <= 1'b1;     r_lds_n <= 1'b1;    r_read <= 1'b1;
      r_bus_oe <= 1'b0;    r_doe <= 1'b0;      r_addr <= '0;
      r_dout <= '0;        r_rdata <= '0;      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state;  r_cnt <= w_cnt;     r_wr <= w_wr;
      r_be <= w_be;        r_last <= w_last;
      r_bg_n <= BGn;       r_bgack_in_n <= BGACKn_in; r_as_in_n <= ASn_in;
      r_dtack_n <= DTACKn; r_berr_n <= BERRn;
      r_br_n <= w_br_n;    r_bgack_n <= w_bgack_n; r_as_n <= w_as_n;
      r_uds_n <= w_uds_n;  r_lds_n <= w_lds_n; r_read <= w_read;
      r_bus_oe <= w_bus_oe; r_doe <= w_doe;    r_addr <= w_addr;
      r_dout <= w_dout;    r_rdata <= w_rdata; r_ack <= w_ack;
      r_err <= w_err;
    end
  end

  assign ack    = r_ack;
  assign err    = r_err;
  assign rdata  = r_rdata;
  assign BRn    = r_br_n;
  assign BGACKn = r_bgack_n;
  assign OWNn   = r_bgack_n;
  assign bus_oe = r_bus_oe;
  assign ADDR   = r_addr;
  assign ASn    = r_as_n;
  assign UDSn   = r_uds_n;
  assign LDSn   = r_lds_n;
  assign READ   = r_read;
  assign D_out  = r_dout;
  assign D_oe   = r_doe;

endmodule

`default_nettype wire

// File: tb/tb_zorro_dma_master.sv
// ============================================================================
// tb_zorro_dma_master
// Directed bench: arbitration, read/write cycles, timeout, hold and reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_zorro_dma_master;

  logic        C7M = 1'b0;
  logic        RESETn, req, req_wr, req_last;
  logic [22:0] req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata, D_in;
  logic        BGn, BGACKn_in, ASn_in, DTACKn, BERRn;
  logic        ack, err, BRn, BGACKn, OWNn, bus_oe, ASn, UDSn, LDSn, READ, D_oe;
  logic [15:0] rdata, D_out;
  logic [22:0] ADDR;

  int checks   = 0;
  int failures = 0;

  always #5 C7M = ~C7M;

  zorro_dma_master #(.TIMEOUT(64), .MAX_HOLD(16)) dut (
    .C7M(C7M), .RESETn(RESETn), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .req_last(req_last), .ack(ack), .err(err), .rdata(rdata),
    .BRn(BRn), .BGn(BGn), .BGACKn_in(BGACKn_in), .BGACKn(BGACKn),
    .OWNn(OWNn), .ASn_in(ASn_in), .DTACKn(DTACKn), .BERRn(BERRn),
    .bus_oe(bus_oe), .ADDR(ADDR), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn),
    .READ(READ), .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
  );

  task automatic tick();
    @(posedge C7M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_brn"}, 32'(BRn), 32'd1);
    chk({tag, "_bgackn"}, 32'(BGACKn), 32'd1);
    chk({tag, "_ownn"}, 32'(OWNn), 32'd1);
    chk({tag, "_strobes"}, {29'd0, ASn, UDSn, LDSn}, 32'h7);
    chk({tag, "_read"}, 32'(READ), 32'd1);
    chk({tag, "_oe"}, {30'd0, bus_oe, D_oe}, 32'h0);
    chk({tag, "_addr"}, 32'(ADDR), 32'h0);
    chk({tag, "_dout"}, 32'(D_out), 32'h0);
    chk({tag, "_rdata"}, 32'(rdata), 32'h0);
    chk({tag, "_ackerr"}, {30'd0, ack, err}, 32'h0);
  endtask

  initial begin
    RESETn = 1'b0; req = 1'b0; req_wr = 1'b0; req_addr = '0; req_be = '0;
    req_wdata = '0; req_last = 1'b0; BGn = 1'b1; BGACKn_in = 1'b1;
    ASn_in = 1'b1; DTACKn = 1'b1; BERRn = 1'b1; D_in = '0;
    tick(); tick();
    chk_reset_state("rst");
    RESETn = 1'b1;
    tick();

    // Read with late grant, released afterwards
    req = 1'b1; req_wr = 1'b0; req_addr = 23'h400010; req_be = 2'b11; req_last = 1'b1;
    tick();
    chk("rd_brn_low", 32'(BRn), 32'd0);
    tick(); tick();
    BGn = 1'b0;
    tick();
    chk("rd_bgack_pending", 32'(BGACKn), 32'd1);
    tick();
    chk("rd_s0_bgackn", 32'(BGACKn), 32'd0);
    chk("rd_s0_ownn", 32'(OWNn), 32'd0);
    chk("rd_s0_brn", 32'(BRn), 32'd1);
    chk("rd_s0_oe", {30'd0, bus_oe, D_oe}, 32'h2);
    chk("rd_s0_addr", 32'(ADDR), 32'h400010);
    chk("rd_s0_read_as", {30'd0, READ, ASn}, 32'h3);
    tick();
    chk("rd_s1_strobes", {29'd0, ASn, UDSn, LDSn}, 32'h0);
    BGn = 1'b1;
    tick();
    DTACKn = 1'b0; D_in = 16'hA55A;
    tick();
    chk("rd_wait_ack", 32'(ack), 32'd0);
    tick();
    chk("rd_term_ackerr", {30'd0, ack, err}, 32'h2);
    chk("rd_term_rdata", 32'(rdata), 32'hA55A);
    chk("rd_term_strobes", {29'd0, ASn, UDSn, LDSn}, 32'h7);
    req = 1'b0; DTACKn = 1'b1;
    tick();
    chk("rd_hold", {30'd0, ack, bus_oe}, 32'h1);
    tick();
    chk("rd_rel", {29'd0, bus_oe, BGACKn, OWNn}, 32'h3);
    tick();

    // Write, upper byte only, last transfer
    req = 1'b1; req_wr = 1'b1; req_addr = 23'h000123; req_be = 2'b10;
    req_wdata = 16'h1234; req_last = 1'b1; BGn = 1'b0;
    tick();
    chk("wr_brn_low", 32'(BRn), 32'd0);
    tick();
    chk("wr_s0_bgackn", 32'(BGACKn), 32'd0);
    chk("wr_s0_doe_read", {30'd0, D_oe, READ}, 32'h2);
    chk("wr_s0_dout", 32'(D_out), 32'h1234);
    tick();
    chk("wr_s1_strobes", {29'd0, ASn, UDSn, LDSn}, 32'h3);
    tick();
    chk("wr_s2_strobes", {29'd0, ASn, UDSn, LDSn}, 32'h1);
    DTACKn = 1'b0;
    tick();
    chk("wr_wait", {30'd0, D_oe, ack}, 32'h2);
    tick();
    chk("wr_term_ackerr", {30'd0, ack, err}, 32'h2);
    chk("wr_term_doe", 32'(D_oe), 32'd1);
    chk("wr_term_uds", 32'(UDSn), 32'd1);
    DTACKn = 1'b1; req = 1'b0; BGn = 1'b1;
    tick();
    chk("wr_hold_doe", 32'(D_oe), 32'd0);
    tick();
    chk("wr_rel", {29'd0, bus_oe, BGACKn, OWNn}, 32'h3);
    tick();

    // Empty byte enable: immediate error ack, no bus request
    req = 1'b1; req_be = 2'b00; req_wr = 1'b0; req_last = 1'b0;
    tick();
    chk("null_ackerr", {30'd0, ack, err}, 32'h3);
    chk("null_brn", 32'(BRn), 32'd1);
    req = 1'b0;
    tick();
    chk("null_done", {30'd0, ack, BRn}, 32'h1);

    // Arbitration blocked by another AS, then timeout
    req = 1'b1; req_wr = 1'b0; req_addr = 23'h0000AA; req_be = 2'b01;
    req_last = 1'b1; BGn = 1'b0; ASn_in = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("arb_blocked", {30'd0, BGACKn, BRn}, 32'h2);
    end
    ASn_in = 1'b1;
    tick();
    chk("arb_as_sync", 32'(BGACKn), 32'd1);
    tick();
    chk("arb_granted", {30'd0, BGACKn, BRn}, 32'h1);
    tick();
    chk("to_s1_strobes", {29'd0, ASn, UDSn, LDSn}, 32'h2);
    tick();
    repeat (63) tick();
    chk("to_before", {30'd0, ack, ASn}, 32'h0);
    tick();
    chk("to_ackerr", {30'd0, ack, err}, 32'h3);
    chk("to_strobes", {29'd0, ASn, UDSn, LDSn}, 32'h7);
    req = 1'b0; BGn = 1'b1;
    tick(); tick();
    chk("to_rel", 32'(bus_oe), 32'd0);
    tick();

    // Back-to-back reads keep the bus, then idle release
    req = 1'b1; req_wr = 1'b0; req_addr = 23'h000100; req_be = 2'b11;
    req_last = 1'b0; BGn = 1'b0;
    tick(); tick(); tick(); tick();
    DTACKn = 1'b0; D_in = 16'h1111;
    tick(); tick();
    chk("b2b1_ackerr", {30'd0, ack, err}, 32'h2);
    chk("b2b1_rdata", 32'(rdata), 32'h1111);
    DTACKn = 1'b1; BGn = 1'b1; req_addr = 23'h000200; D_in = 16'h2222;
    tick();
    chk("b2b_hold", {28'd0, ack, BRn, BGACKn, bus_oe}, 32'h5);
    tick();
    chk("b2b2_s0_addr", 32'(ADDR), 32'h000200);
    chk("b2b2_s0_bus", {30'd0, BRn, BGACKn}, 32'h2);
    tick(); tick();
    DTACKn = 1'b0;
    tick(); tick();
    chk("b2b2_ack", 32'(ack), 32'd1);
    chk("b2b2_rdata", 32'(rdata), 32'h2222);
    DTACKn = 1'b1; req = 1'b0;
    tick();
    repeat (15) tick();
    chk("hold_kept", {30'd0, bus_oe, BGACKn}, 32'h2);
    tick();
    chk("hold_released", {29'd0, bus_oe, BGACKn, BRn}, 32'h3);
    tick();

    // BERRn and DTACKn together: error wins, rdata untouched
    req = 1'b1; req_addr = 23'h000300; req_be = 2'b11; req_last = 1'b1; BGn = 1'b0;
    tick(); tick(); tick(); tick();
    DTACKn = 1'b0; BERRn = 1'b0; D_in = 16'hDEAD;
    tick(); tick();
    chk("berr_ackerr", {30'd0, ack, err}, 32'h3);
    chk("berr_rdata", 32'(rdata), 32'h2222);
    DTACKn = 1'b1; BERRn = 1'b1; req = 1'b0; BGn = 1'b1;
    tick(); tick();
    chk("berr_rel", 32'(bus_oe), 32'd0);
    tick();

    // Reset during WAIT aborts without ack
    req = 1'b1; req_addr = 23'h000400; req_last = 1'b1; BGn = 1'b0;
    repeat (6) tick();
    chk("rstw_inwait", {30'd0, ack, ASn}, 32'h0);
    RESETn = 1'b0;
    tick();
    chk_reset_state("rstw");
    RESETn = 1'b1; req = 1'b0; BGn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstw_quiet", {30'd0, ack, BRn}, 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/zorro_dma_master.md
Name: zorro_dma_master

Overview:
- Zorro II bus-master engine for expansion cards: the requesting end of the mainboard arbitration and steering logic.
- Requests the bus on BRn, waits for BGn, takes ownership with BGACKn/OWNn, then runs one or more 16-bit read/write cycles terminated by DTACKn or BERRn.
- Local side is a simple req/ack transfer port driven by the card's DMA controller. Top level converts open-drain outputs (1 = released) and the drive-enable outputs into pad tristates.

Parameters:
- TIMEOUT, 64, C7M cycles waited for DTACKn/BERRn before local bus-error termination.
- MAX_HOLD, 16, C7M cycles the bus is kept idle between transfers before automatic release.

Ports:
- C7M  input  1  7 MHz bus clock; all logic on rising edge.
- RESETn  input  1  reset, synchronous, active-low.
- req  input  1  transfer request; held high until ack.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  23  word address A[23:1].
- req_be  input  2  byte enables: [1] = UDS, [0] = LDS.
- req_wdata  input  16  write data.
- req_last  input  1  release the bus after this transfer.
- ack  output  1  one-cycle completion pulse.
- err  output  1  high with ack when the cycle ended by bus error or timeout.
- rdata  output  16  read data; valid from the ack cycle until the next ack.
- BRn  output  1  bus request.
- BGn  input  1  bus grant.
- BGACKn_in  input  1  bus BGACK (other owners).
- BGACKn  output  1  our bus-grant acknowledge (open-drain).
- OWNn  output  1  card owns bus; equals BGACKn.
- ASn_in  input  1  bus address strobe.
- DTACKn  input  1  data acknowledge.
- BERRn  input  1  bus error.
- bus_oe  output  1  enables ADDR/ASn/UDSn/LDSn/READ drivers.
- ADDR  output  23  address A[23:1].
- ASn  output  1  address strobe.
- UDSn  output  1  upper data strobe.
- LDSn  output  1  lower data strobe.
- READ  output  1  1 = read.
- D_out  output  16  write data.
- D_oe  output  1  data driver enable.
- D_in  input  16  read data.

Behaviour:
- Input registration: BGn, BGACKn_in, ASn_in, DTACKn and BERRn pass through one register stage. Every reference below means the registered value, so each adds one cycle of latency.
- Reset values (RESETn low at an edge, any state, aborts with no ack): BRn=1, BGACKn=OWNn=1, ASn=UDSn=LDSn=1, READ=1, bus_oe=0, D_oe=0, ADDR=0, D_out=0, rdata=0, ack=err=0; state IDLE; counters 0.
- IDLE:
  - req=1 and req_be=00 -> ack=err=1 next cycle, no bus activity.
  - req=1 and req_be!=00 -> BRn=0 next cycle, go ARB.
- ARB: stays while BRn=0. When BGn=0, ASn_in=1, BGACKn_in=1 and DTACKn=1 all hold, the next cycle drives BGACKn=OWNn=0 and BRn=1, then goes S0.
- S0 (1 cycle):
  - bus_oe=1; ADDR=req_addr; READ=!req_wr.
  - D_oe=req_wr; D_out=req_wdata.
  - Strobes high.
- S1 (1 cycle): ASn=0. For a read, UDSn/LDSn = !req_be here.
- S2 (1 cycle): for a write, UDSn/LDSn = !req_be here (one cycle after AS). For a read, strobes are unchanged.
- WAIT: timeout counter increments each cycle from S2.
  - BERRn=0 -> err.
  - Else DTACKn=0 -> for a read, rdata<=D_in.
  - Else counter==TIMEOUT -> err.
  - Any of these -> TERM. BERRn wins over DTACKn when both arrive together.
- TERM (1 cycle): ASn=UDSn=LDSn=1; ack=1; err as determined in WAIT; D_oe held. Go HOLD.
- HOLD:
  - D_oe=0; bus_oe stays 1 with strobes high. Waits for DTACKn=1 and BERRn=1 before any further action.
  - req_last on the completed transfer -> REL.
  - Else new req with req_be!=00 -> S0.
  - Else new req with req_be=00 -> ack=err=1 pulse, stay in HOLD.
  - Hold counter reaches MAX_HOLD with no req -> REL.
- REL (1 cycle): bus_oe=0, BGACKn=OWNn=1. Go IDLE; BRn cannot reassert until the cycle after IDLE is entered.
- Constraints:
  - ack is a single cycle; req may drop or change in the cycle after ack.
  - BRn and BGACKn are never both low for more than the one handover cycle.
  - ASn is never low when bus_oe=0.
  - Minimum read from ARB exit to ack: S0, S1, S2, ≥1 WAIT, TERM.

Test Plan:
- Read, req_addr=0x400010, be=11: BGn low 3 cycles after BRn -> BGACKn low, BRn high; ASn/UDSn/LDSn low together; DTACKn low with D_in=0xA55A -> ack, rdata=0xA55A, err=0.
- Write with req_last=1, be=10, wdata=0x1234: UDSn low one cycle after ASn, LDSn stays high; D_oe=1 through TERM; after DTACKn -> ack, then REL with BGACKn=1, bus_oe=0.
- Arbitration blocking: BGn low while ASn_in=0 for 5 cycles -> BGACKn stays high until ASn_in is high, then asserts.
- No DTACKn, TIMEOUT=64 -> ack with err=1 exactly 64 cycles after S2; strobes released.
- Two back-to-back reads, first req_last=0 -> bus kept; second starts at S0 with no BRn reassertion. Then idle MAX_HOLD=16 cycles -> automatic release.
- RESETn low during WAIT -> next edge all outputs at reset values, no ack. Also: BERRn and DTACKn asserted in the same cycle -> err=1.
